// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory port between two requesters.
//   Port 0 is the core's fetch/data port, port 1 the loader / debug DMA.
//   One access is accepted per cycle. Ownership rotates fairly: an owner keeps
//   the port for at most BURST_MAX consecutive accepts while the other port is
//   requesting. Read data returns exactly one cycle after the accept.
//
// Ports:
//   clk                         system clock, all state on the rising edge
//   reset                       asynchronous, active-low reset
//   req0/we0/addr0/wdata0       port 0 request, write flag, address, write data
//   gnt0                        port 0 access accepted this cycle (combinational)
//   rvalid0/rdata0              port 0 read data return
//   req1 ... rdata1             same as port 0, for port 1
//   mem_addr/mem_wdata/mem_we   memory command bus (zero when nothing granted)
//   mem_rdata                   memory read data, valid the cycle after its address
module mem_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  owner_t     owner_reg, owner_next;
  logic       last_reg, last_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       rd_pend0_reg, rd_pend1_reg;
  logic       grant0, grant1;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg    <= IDLE;
      last_reg     <= 1'b1;
      cnt_reg      <= 4'd0;
      rd_pend0_reg <= 1'b0;
      rd_pend1_reg <= 1'b0;
    end else begin
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      rd_pend0_reg <= grant0 & ~we0;
      rd_pend1_reg <= grant1 & ~we1;
    end
  end

  // Grant decision and next-state logic.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    owner_next = IDLE;
    last_next  = last_reg;
    cnt_next   = 4'd0;

    case (owner_reg)
      IDLE: begin
        // On a tie the port that was not granted most recently wins; last
        // resets to 1 so the first tie after reset goes to port 0.
        if (req0 && req1) begin
          if (last_reg) grant0 = 1'b1;
          else          grant1 = 1'b1;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
      OWN0: begin
        if (req0) begin
          if (req1 && cnt_reg == BURST_LIM) grant1 = 1'b1;
          else                              grant0 = 1'b1;
        end else begin
          grant1 = req1;
        end
      end
      OWN1: begin
        if (req1) begin
          if (req0 && cnt_reg == BURST_LIM) grant0 = 1'b1;
          else                              grant1 = 1'b1;
        end else begin
          grant0 = req0;
        end
      end
      default: ;
    endcase

    // cnt saturates at BURST_MAX so a lone requester keeps the port forever
    // and a newly arriving requester is served on the very next cycle.
    if (grant0) begin
      owner_next = OWN0;
      last_next  = 1'b0;
      if (owner_reg == OWN0)
        cnt_next = (cnt_reg >= BURST_LIM) ? BURST_LIM : cnt_reg + 4'd1;
      else
        cnt_next = 4'd1;
    end else if (grant1) begin
      owner_next = OWN1;
      last_next  = 1'b1;
      if (owner_reg == OWN1)
        cnt_next = (cnt_reg >= BURST_LIM) ? BURST_LIM : cnt_reg + 4'd1;
      else
        cnt_next = 4'd1;
    end
  end

  // Grants are Mealy outputs; mask them while reset is held so nothing
  // reaches the memory bus even though requests may be active.
  assign gnt0 = grant0 & reset;
  assign gnt1 = grant1 & reset;

  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);

  assign rvalid0 = rd_pend0_reg;
  assign rvalid1 = rd_pend1_reg;
  assign rdata0  = rd_pend0_reg ? mem_rdata : '0;
  assign rdata1  = rd_pend1_reg ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (WIDTH=8, BURST_MAX=4) with a small
// synchronous-read memory model behind the arbiter.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] mem [256];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(8), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    step(); step(); #1;
    $display("reset held: gnt0=%b gnt1=%b mem_we=%b rvalid0=%b rvalid1=%b", gnt0, gnt1, mem_we, rvalid0, rvalid1);
    total++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0 got %b want 0", gnt0); else passed++;
    total++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1 got %b want 0", gnt1); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else passed++;
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
      $display("FAIL reset_rvalid got %b%b want 00", rvalid0, rvalid1); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got %h want 00", mem_addr); else passed++;
    reset = 1'b1; #1;
    $display("reset released: gnt0=%b gnt1=%b", gnt0, gnt1);
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
      $display("FAIL reset_first_tie got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); else passed++;
    step();
    idle(2);
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; #1;
    $display("read accept: gnt0=%b mem_addr=%h mem_we=%b", gnt0, mem_addr, mem_we);
    total++; if (gnt0 !== 1'b1) $display("FAIL read_gnt0 got %b want 1", gnt0); else passed++;
    total++; if (mem_addr !== 8'h10) $display("FAIL read_mem_addr got %h want 10", mem_addr); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL read_mem_we got %b want 0", mem_we); else passed++;
    step();
    req0 = 1'b0; #1;
    $display("read return: rvalid0=%b rdata0=%h rvalid1=%b", rvalid0, rdata0, rvalid1);
    total++; if (rvalid0 !== 1'b1) $display("FAIL read_rvalid0 got %b want 1", rvalid0); else passed++;
    total++; if (rdata0 !== 8'hAB) $display("FAIL read_rdata0 got %h want ab", rdata0); else passed++;
    total++; if (rvalid1 !== 1'b0) $display("FAIL read_rvalid1 got %b want 0", rvalid1); else passed++;
    step(); #1;
    total++; if (rvalid0 !== 1'b0 || rdata0 !== 8'h00)
      $display("FAIL read_rvalid0_drop got %b/%h want 0/00", rvalid0, rdata0); else passed++;
    idle(2);
  endtask

  task automatic test_contention();
    int pat [9];
    logic [7:0] exp_addr;
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    // Restart from reset so last=1 and the first tie goes to port 0.
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0; step(); reset = 1'b1; step();
    for (int i = 0; i < 9; i++) begin
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      addr0 = 8'h80 + 8'(i); addr1 = 8'h90 + 8'(i);
      wdata0 = 8'h00; wdata1 = 8'h00; #1;
      exp_addr = (pat[i] == 1) ? 8'h90 + 8'(i) : 8'h80 + 8'(i);
      $display("contention cyc %0d: gnt0=%b gnt1=%b mem_addr=%h", i, gnt0, gnt1, mem_addr);
      total++; if (gnt0 !== (pat[i] == 0) || gnt1 !== (pat[i] == 1))
        $display("FAIL contention_cyc%0d got gnt0=%b gnt1=%b want port %0d", i, gnt0, gnt1, pat[i]); else passed++;
      total++; if (mem_addr !== exp_addr)
        $display("FAIL contention_addr%0d got %h want %h", i, mem_addr, exp_addr); else passed++;
      step();
    end
    idle(2);
  endtask

  task automatic test_lone_burst();
    for (int i = 0; i < 10; i++) begin
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'(i); wdata1 = 8'h50 + 8'(i); #1;
      $display("burst cyc %0d: gnt1=%b mem_we=%b mem_addr=%h mem_wdata=%h", i, gnt1, mem_we, mem_addr, mem_wdata);
      total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0)
        $display("FAIL burst_gnt%0d got gnt0=%b gnt1=%b want 0 1", i, gnt0, gnt1); else passed++;
      total++; if (mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_wdata !== 8'h50 + 8'(i))
        $display("FAIL burst_bus%0d got we=%b addr=%h wdata=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, 8'(i), 8'h50 + 8'(i)); else passed++;
      total++; if (rvalid1 !== 1'b0) $display("FAIL burst_rvalid%0d got %b want 0", i, rvalid1); else passed++;
      step();
    end
    // Read one written word back through port 1.
    we1 = 1'b0; addr1 = 8'h03; #1;
    total++; if (gnt1 !== 1'b1) $display("FAIL burst_readback_gnt got %b want 1", gnt1); else passed++;
    step();
    req1 = 1'b0; #1;
    $display("burst readback: rvalid1=%b rdata1=%h", rvalid1, rdata1);
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h53)
      $display("FAIL burst_readback got %b/%h want 1/53", rvalid1, rdata1); else passed++;
    idle(2);
  endtask

  task automatic test_early_release();
    int r0 [7];
    int r1 [7];
    int ex [7];
    r0 = '{1, 1, 0, 1, 1, 1, 1};
    r1 = '{0, 1, 1, 1, 1, 1, 1};
    ex = '{0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      req0 = (r0[i] == 1); req1 = (r1[i] == 1); we0 = 1'b1; we1 = 1'b1;
      addr0 = 8'hA0; addr1 = 8'hB0; #1;
      $display("release cyc %0d: req0=%b req1=%b gnt0=%b gnt1=%b", i, req0, req1, gnt0, gnt1);
      total++; if (gnt0 !== (ex[i] == 0) || gnt1 !== (ex[i] == 1))
        $display("FAIL release_cyc%0d got gnt0=%b gnt1=%b want port %0d", i, gnt0, gnt1, ex[i]); else passed++;
      step();
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; #1;
    total++; if (gnt0 !== 1'b1) $display("FAIL midreset_gnt0 got %b want 1", gnt0); else passed++;
    #2;
    reset = 1'b0; req0 = 1'b0; #1;
    total++; if (gnt0 !== 1'b0) $display("FAIL midreset_gnt_in_reset got %b want 0", gnt0); else passed++;
    step();
    $display("mid-read reset: rvalid0=%b rdata0=%h", rvalid0, rdata0);
    total++; if (rvalid0 !== 1'b0 || rdata0 !== 8'h00)
      $display("FAIL midreset_rvalid0 got %b/%h want 0/00", rvalid0, rdata0); else passed++;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 8'hC0; addr1 = 8'hD0; #1;
    $display("after reset tie: gnt0=%b gnt1=%b", gnt0, gnt1);
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
      $display("FAIL midreset_tie got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1); else passed++;
    step();
    idle(2);
  endtask

  task automatic test_back_to_back();
    // last=0 here, so this tie goes to port 1.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hC0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h04; #1;
    $display("b2b cyc 0: gnt0=%b gnt1=%b", gnt0, gnt1);
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0)
      $display("FAIL b2b_tie got gnt0=%b gnt1=%b want 0 1", gnt0, gnt1); else passed++;
    step();
    addr1 = 8'h05; #1;
    $display("b2b cyc 1: gnt1=%b rvalid1=%b rdata1=%h", gnt1, rvalid1, rdata1);
    total++; if (gnt1 !== 1'b1) $display("FAIL b2b_gnt1 got %b want 1", gnt1); else passed++;
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h54)
      $display("FAIL b2b_first got %b/%h want 1/54", rvalid1, rdata1); else passed++;
    step();
    req1 = 1'b0; #1;
    $display("b2b cyc 2: gnt0=%b rvalid1=%b rdata1=%h", gnt0, rvalid1, rdata1);
    total++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt0 got %b want 1", gnt0); else passed++;
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h55)
      $display("FAIL b2b_second got %b/%h want 1/55", rvalid1, rdata1); else passed++;
    step();
    req0 = 1'b0; #1;
    total++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0)
      $display("FAIL b2b_write_no_rvalid got %b%b want 00", rvalid0, rvalid1); else passed++;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hAB;
    test_reset();
    test_single_read();
    test_contention();
    test_lone_burst();
    test_early_release();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port of the multicycle core between two requesters: port 0 (core instruction/data fetch) and port 1 (program loader / debug DMA).
- One access is accepted per cycle. Ownership rotates fairly, with bounded bursts.
- Memory read is synchronous: data returns one cycle after the address is presented.
- Sits between the core/loader and the memory model, on the same WIDTH-bit address/data bus.

Parameters:
- WIDTH, 8, address and data width of all ports.
- BURST_MAX, 4, max consecutive accepts by one owner while the other port is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0  in  1  port 0 access request, held until granted
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  WIDTH  port 0 address
- wdata0  in  WIDTH  port 0 write data
- gnt0  out  1  port 0 access accepted this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  WIDTH  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  WIDTH  memory read data, valid the cycle after its address

Behaviour:
- Registered state:
  - owner: IDLE, OWN0 or OWN1; the port granted in the previous cycle.
  - last: the most recent port granted, or 1 out of reset.
  - cnt: consecutive-accept count, 4 bits.
  - rd_pend0, rd_pend1: pending-read flags.
- Reset (reset=0, asynchronous): owner=IDLE, last=1, cnt=0, rd_pend0/1=0.
  - Outputs while in reset: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A read accepted in the cycle before reset asserts never produces rvalid.
- Grant decision is combinational (Mealy) from req0, req1, owner, cnt. At most one gnt per cycle.
  - owner=IDLE:
    - Only reqN: grant N.
    - Both requesting: grant the port != last. First tie after reset goes to port 0.
    - Neither: no grant.
  - owner=OWNx, reqx=1:
    - Other port requesting and cnt==BURST_MAX: grant the other port.
    - Otherwise: grant x.
  - owner=OWNx, reqx=0:
    - Other port requesting: grant the other port.
    - Otherwise: no grant.
- State update at clock edge:
  - Grant to N with N==owner: cnt=min(cnt+1, BURST_MAX).
  - Grant to N with N!=owner: cnt=1.
  - owner=OWNN and last=N on any grant to N.
  - No grant: owner=IDLE, cnt=0, last unchanged.
  - cnt saturates at BURST_MAX; a lone requester keeps its grant indefinitely.
- BURST_MAX=1 gives strict alternation under contention.
- Memory bus:
  - While gntN=1: mem_addr=addrN, mem_wdata=wdataN, mem_we=weN.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - rd_pendN <= gntN & ~weN.
  - rvalidN = rd_pendN.
  - rdataN = mem_rdata when rvalidN=1, else 0.
  - Latency from accept to data is exactly 1 cycle.
  - Back-to-back reads give rvalid every cycle. Writes never produce rvalid.
- Requester rules:
  - A requester holds req/we/addr/wdata stable until its gnt is seen.
  - It may drop req in the cycle after gnt.
  - The arbiter does not check these rules.
- Simultaneous read return and new grant to the other port in the same cycle are legal and independent.
- Core usage: port 0 is tied to the core's addr/writedata/memwrite. The core's hold/stall is derived externally from req0 & ~gnt0; the arbiter has no core-specific logic.

Test Plan:
1. Reset: hold reset=0 with req0=req1=1 → gnt0=gnt1=0, mem_we=0, rvalid0/1=0. Release reset → first cycle gnt0=1 (tie goes to port 0).
2. Single read: req0=1, we0=0, addr0=0x10; memory returns 0xAB the next cycle → gnt0=1 and mem_addr=0x10 in cycle 0; rvalid0=1 and rdata0=0xAB in cycle 1; rvalid1=0 throughout.
3. Contention, BURST_MAX=4: req0=req1=1 continuously from IDLE → grant pattern 0,0,0,0,1,1,1,1,0,… ; exactly one gnt per cycle.
4. Lone burst: req1=1 with we1=1 for 10 cycles, addr1 incrementing 0x00..0x09 → gnt1=1 every cycle, mem_we=1 with matching mem_addr, no rotation, no rvalid.
5. Early release: port 0 owns with cnt=2 and port 1 requesting; req0 drops → gnt1=1 the next cycle with cnt=1. Port 1 then gets a full 4-cycle burst.
6. Reset mid-read: read accepted at cycle n, reset=0 asserted before edge n+1 → rvalid0 stays 0. After release, owner=IDLE and the next tie goes to port 0.
